control_merge: RTL and testbench

- Nondeterministic merge of SIZE dataflow input channels into one data output, plus an index output that reports which input won.
- Sits directly upstream of the dataflow mux. The index output drives the mux select channel, so downstream muxes can steer data along the path that control actually took.
- Internally it is arbitration, then a one-slot transparent elastic buffer (TEHB), then an eager two-way fork (data, index).

---
 rtl/control_merge.sv | 158 +++++++++++++++
 tb/tb_control_merge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/control_merge.sv
// control_merge: nondeterministic merge of SIZE dataflow inputs into one data
// output plus an index output naming the granted input. The index output is
// meant to drive the select of a downstream dataflow mux.
//
// Datapath: arbiter -> one-slot transparent elastic buffer (TEHB) -> eager
// two-way fork (data, index). With the buffer empty, the arbiter output
// reaches the fork in the same cycle. If only one fork branch accepts, the
// token is held in the buffer until the other branch takes it.
//
// Parameters:
//   SIZE        number of input channels (>= 2, SIZE <= 2**INDEX_TYPE)
//   DATA_TYPE   width of each data token
//   INDEX_TYPE  width of the index output
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   ins / ins_valid / ins_ready     packed input channels, channel i at
//                                   ins[i*DATA_TYPE +: DATA_TYPE]
//   outs / outs_valid / outs_ready  merged data output
//   index / index_valid / index_ready  granted-input number output
//   While rst is high, every output is driven to 0.
//
// Optional feature: define CONTROL_MERGE_ROUND_ROBIN_EN for round-robin
// arbitration. The search starts at a pointer, and the pointer advances
// past the winner on every input handshake. Without the macro, the lowest
// valid input always wins.
module control_merge #(
    parameter int SIZE       = 2,
    parameter int DATA_TYPE  = 32,
    parameter int INDEX_TYPE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE*DATA_TYPE-1:0] ins,
    input  logic [SIZE-1:0]           ins_valid,
    output logic [SIZE-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]      outs,
    output logic                      outs_valid,
    input  logic                      outs_ready,
    output logic [INDEX_TYPE-1:0]     index,
    output logic                      index_valid,
    input  logic                      index_ready
);
    localparam int PTR_W = $clog2(SIZE);

    logic                  full_q, full_d;
    logic [DATA_TYPE-1:0]  data_q, data_d;
    logic [INDEX_TYPE-1:0] index_q, index_d;
    logic                  sent_d_q, sent_d_d;
    logic                  sent_i_q, sent_i_d;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
    logic [PTR_W-1:0]      ptr_q, ptr_d;
`endif

    logic                  arb_valid;
    logic [PTR_W-1:0]      grant;
    logic [DATA_TYPE-1:0]  arb_data;
    logic [INDEX_TYPE-1:0] arb_index;
    logic                  entry_valid;
    logic [DATA_TYPE-1:0]  entry_data;
    logic [INDEX_TYPE-1:0] entry_index;
    logic                  fork_outs_valid, fork_index_valid;
    logic                  fork_done;

    // Arbitration: the first valid input in search order wins.
    always_comb begin
        int idx;
        arb_valid = 1'b0;
        grant     = '0;
        arb_data  = '0;
        idx       = 0;
        for (int k = 0; k < SIZE; k++) begin
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
            idx = (int'(ptr_q) + k) % SIZE;
`else
            idx = k;
`endif
            if (!arb_valid && ins_valid[idx]) begin
                arb_valid = 1'b1;
                grant     = PTR_W'(idx);
                arb_data  = ins[idx*DATA_TYPE +: DATA_TYPE];
            end
        end
        arb_index = INDEX_TYPE'(grant);
    end

    always_comb begin
        entry_valid      = full_q | arb_valid;
        entry_data       = full_q ? data_q  : arb_data;
        entry_index      = full_q ? index_q : arb_index;
        fork_outs_valid  = entry_valid & ~sent_d_q;
        fork_index_valid = entry_valid & ~sent_i_q;
        fork_done        = entry_valid & (sent_d_q | outs_ready) & (sent_i_q | index_ready);

        for (int i = 0; i < SIZE; i++) begin
            ins_ready[i] = ~rst & arb_valid & ~full_q & (grant == PTR_W'(i));
        end
        outs_valid  = ~rst & fork_outs_valid;
        index_valid = ~rst & fork_index_valid;
        outs        = rst ? '0 : entry_data;
        index       = rst ? '0 : entry_index;
    end

    // Next state of the buffer, the fork sent flags and the pointer.
    always_comb begin
        full_d   = full_q;
        data_d   = data_q;
        index_d  = index_q;
        sent_d_d = sent_d_q;
        sent_i_d = sent_i_q;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
        if (arb_valid && !full_q) begin
            ptr_d = (int'(grant) == SIZE - 1) ? '0 : grant + PTR_W'(1);
        end
`endif
        // Capture the arbiter output whenever the fork cannot finish with it.
        // The input still handshakes, so the token has to be kept here.
        if (!full_q && arb_valid && !fork_done) begin
            full_d  = 1'b1;
            data_d  = arb_data;
            index_d = arb_index;
        end else if (full_q && fork_done) begin
            full_d = 1'b0;
        end

        if (fork_done) begin
            sent_d_d = 1'b0;
            sent_i_d = 1'b0;
        end else if (entry_valid) begin
            sent_d_d = sent_d_q | (fork_outs_valid & outs_ready);
            sent_i_d = sent_i_q | (fork_index_valid & index_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            data_q   <= '0;
            index_q  <= '0;
            sent_d_q <= 1'b0;
            sent_i_q <= 1'b0;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            full_q   <= full_d;
            data_q   <= data_d;
            index_q  <= index_d;
            sent_d_q <= sent_d_d;
            sent_i_q <= sent_i_d;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_control_merge.sv
// Bench for control_merge with SIZE=2, DATA_TYPE=32, INDEX_TYPE=1.
//
// The token model tracks the token in flight as a record: which input it
// came from, its data, and which consumers have already taken it. On every
// cycle it predicts the DUT outputs. Directed checks with hand-computed
// literal values pin each test-plan scenario.
module tb_control_merge;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ins;
    logic [1:0]  ins_valid;
    logic [1:0]  ins_ready;
    logic [31:0] outs;
    logic        outs_valid;
    logic        outs_ready;
    logic [0:0]  index;
    logic        index_valid;
    logic        index_ready;

    int checks   = 0;
    int failures = 0;

    control_merge #(.SIZE(2), .DATA_TYPE(32), .INDEX_TYPE(1)) dut (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready),
        .index(index), .index_valid(index_valid), .index_ready(index_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- token model ----------------
    bit          m_has;        // a token is held waiting for a consumer
    logic [31:0] m_data;
    int          m_src;
    bit          m_dgot, m_igot;
    int          m_ptr;

    // Compare process: the inputs are stable from posedge+1 until the next
    // posedge, so the negedge sees the values the edge will act on.
    always @(negedge clk) begin
        int          w;
        bit          cur_v;
        logic [31:0] cur_d;
        int          cur_s;
        bit          exp_ov, exp_iv, dt, it, dg, ig;
        logic [1:0]  exp_rdy;
        if (rst) begin
            chk("mdl_rst_ins_ready", {30'd0, ins_ready}, 32'd0);
            chk("mdl_rst_valids", {30'd0, outs_valid, index_valid}, 32'd0);
            chk("mdl_rst_outs", outs, 32'd0);
            chk("mdl_rst_index", {31'd0, index}, 32'd0);
            m_has = 0; m_dgot = 0; m_igot = 0; m_ptr = 0;
        end else begin
            w = -1;
            for (int k = 0; k < 2; k++) begin
                int j;
                j = (m_ptr + k) % 2;
                if (w < 0 && ins_valid[j]) w = j;
            end
            exp_rdy = 2'b00;
            if (m_has) begin
                cur_v = 1; cur_d = m_data; cur_s = m_src;
            end else if (w >= 0) begin
                cur_v = 1; cur_d = ins[w*32 +: 32]; cur_s = w;
                exp_rdy[w] = 1'b1;
            end else begin
                cur_v = 0; cur_d = '0; cur_s = 0;
            end
            exp_ov = cur_v && !m_dgot;
            exp_iv = cur_v && !m_igot;
            chk("mdl_ins_ready", {30'd0, ins_ready}, {30'd0, exp_rdy});
            chk("mdl_outs_valid", {31'd0, outs_valid}, {31'd0, exp_ov});
            chk("mdl_index_valid", {31'd0, index_valid}, {31'd0, exp_iv});
            if (exp_ov) chk("mdl_outs", outs, cur_d);
            if (exp_iv) chk("mdl_index", {31'd0, index}, cur_s);
            dt = exp_ov && outs_ready;
            it = exp_iv && index_ready;
            dg = m_dgot || dt;
            ig = m_igot || it;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
            if (!m_has && w >= 0) m_ptr = (w + 1) % 2;
`endif
            if (cur_v) begin
                if (dg && ig) begin
                    m_has = 0; m_dgot = 0; m_igot = 0;
                end else begin
                    m_has = 1; m_data = cur_d; m_src = cur_s; m_dgot = dg; m_igot = ig;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic ordy, input logic irdy);
        ins_valid   = v;
        ins         = {d1, d0};
        outs_ready  = ordy;
        index_ready = irdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b11, 32'h11, 32'h22, 1'b1, 1'b1);
        // Reset: two cycles with both inputs valid.
        @(posedge clk); #3;
        chk("rst_ins_ready", {30'd0, ins_ready}, 32'd0);
        chk("rst_outs_valid", {31'd0, outs_valid}, 32'd0);
        chk("rst_index_valid", {31'd0, index_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        chk("post_rst_outs", outs, 32'h11);
        chk("post_rst_index", {31'd0, index}, 32'd0);
        chk("post_rst_ins_ready", {30'd0, ins_ready}, 32'b01);

        // Pass-through of input 1.
        cyc(); drive(2'b10, 32'h0, 32'hA5, 1'b1, 1'b1); #2;
        chk("pt_outs", outs, 32'hA5);
        chk("pt_index", {31'd0, index}, 32'd1);
        chk("pt_ins_ready", {30'd0, ins_ready}, 32'b10);
        cyc(); drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1); #2;
        chk("pt_tehb_empty", {31'd0, outs_valid}, 32'd0);

        // Split acceptance: data taken in cycle 0, index held until cycle 3.
        cyc(); drive(2'b01, 32'h11, 32'h0, 1'b1, 1'b0); #2;
        chk("split_c0_ins_ready", {30'd0, ins_ready}, 32'b01);
        chk("split_c0_outs", outs, 32'h11);
        for (int c = 1; c <= 3; c++) begin
            cyc(); drive(2'b01, 32'h11, 32'h0, 1'b1, (c == 3)); #2;
            chk("split_ins_ready", {30'd0, ins_ready}, 32'b00);
            chk("split_outs_valid", {31'd0, outs_valid}, 32'd0);
            chk("split_index_valid", {31'd0, index_valid}, 32'd1);
            chk("split_index", {31'd0, index}, 32'd0);
        end
        cyc(); drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1); #2;
        chk("split_index_once", {31'd0, index_valid}, 32'd0);

        // Contention: both inputs valid and both consumers ready.
        for (int c = 0; c < 4; c++) begin
            cyc(); drive(2'b11, 32'h11, 32'h22, 1'b1, 1'b1); #2;
`ifdef CONTROL_MERGE_ROUND_ROBIN_EN
            // The last grant was input 0, so input 1 comes first.
            chk("cont_rr_outs", outs, (c % 2 == 0) ? 32'h22 : 32'h11);
            chk("cont_rr_index", {31'd0, index}, (c % 2 == 0) ? 32'd1 : 32'd0);
`else
            chk("cont_outs", outs, 32'h11);
            chk("cont_ins_ready", {30'd0, ins_ready}, 32'b01);
`endif
        end

        // Backpressure: token held, input data changes underneath.
        cyc(); drive(2'b01, 32'h11, 32'h0, 1'b0, 1'b0); #2;
        chk("bp_c0_ins_ready", {30'd0, ins_ready}, 32'b01);
        for (int c = 1; c <= 2; c++) begin
            cyc(); drive(2'b01, 32'h33, 32'h0, 1'b0, 1'b0); #2;
            chk("bp_hold_ins_ready", {30'd0, ins_ready}, 32'b00);
            chk("bp_hold_outs", outs, 32'h11);
            chk("bp_hold_index", {31'd0, index}, 32'd0);
            chk("bp_hold_valids", {30'd0, outs_valid, index_valid}, 32'b11);
        end
        cyc(); drive(2'b01, 32'h33, 32'h0, 1'b1, 1'b1); #2;
        chk("bp_release_outs", outs, 32'h11);
        chk("bp_release_ins_ready", {30'd0, ins_ready}, 32'b00);
        cyc(); drive(2'b00, 32'h33, 32'h0, 1'b1, 1'b1);
        ins_valid = 2'b01; #2;
        chk("bp_next_outs", outs, 32'h33);
        chk("bp_next_ins_ready", {30'd0, ins_ready}, 32'b01);

        // Reset mid-token: data already sent, index pending.
        cyc(); drive(2'b01, 32'h44, 32'h0, 1'b1, 1'b0); #2;
        chk("rm_c0_outs", outs, 32'h44);
        cyc(); rst = 1'b1; drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1); #2;
        chk("rm_rst_valids", {30'd0, outs_valid, index_valid}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            cyc(); rst = 1'b0; #2;
            chk("rm_after_valids", {30'd0, outs_valid, index_valid}, 32'd0);
        end
        cyc(); drive(2'b01, 32'h55, 32'h0, 1'b1, 1'b1); #2;
        chk("rm_new_outs", outs, 32'h55);
        chk("rm_new_index", {31'd0, index}, 32'd0);
        cyc(); drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
